programmable_freq_divider: RTL and testbench

PROGRAMMABLE_FREQ_DIVIDER -- requirements
Module: programmable_freq_divider

---
 rtl/programmable_freq_divider.sv | 167 ++++++++++++++++
 tb/tb_programmable_freq_divider.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/programmable_freq_divider.sv
// Multi-channel programmable frequency divider.
// Each channel counts enabled cycles modulo a per-channel divisor M and produces
// a terminal-count tick plus a flag output shaped by the channel mode
// (TOGGLE: square wave of period 2*M, PULSE: flag mirrors tick,
// ONESHOT: flag/done latch high after the first terminal count).
// A single configuration port reloads one channel's divisor and mode.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   enable     per-channel count enable
//   cfg_valid  configuration request
//   cfg_ch     target channel of the request
//   cfg_max    new divisor M (0 behaves as 1)
//   cfg_mode   00 TOGGLE, 01 PULSE, 10 ONESHOT, 11 TOGGLE
//   cfg_ready  configuration port can accept a request
//   cfg_err    one-cycle pulse when an accepted request names a missing channel
//   flag       per-channel divided output
//   tick       per-channel one-cycle terminal-count pulse
//   done       per-channel one-shot completion
//   CountOut   per-channel count, channel i at [i*NBITS_FOR_COUNTER +: NBITS_FOR_COUNTER]
module programmable_freq_divider #(
    parameter int unsigned BASE_CLK          = 50_000_000,
    parameter int unsigned TARGET_FREQUENCY  = 100_000,
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned NBITS_FOR_COUNTER = 16,
    localparam int unsigned CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CH-1:0]                   enable,
    input  logic                                cfg_valid,
    input  logic [CH_W-1:0]                     cfg_ch,
    input  logic [NBITS_FOR_COUNTER-1:0]        cfg_max,
    input  logic [1:0]                          cfg_mode,
    output logic                                cfg_ready,
    output logic                                cfg_err,
    output logic [NUM_CH-1:0]                   flag,
    output logic [NUM_CH-1:0]                   tick,
    output logic [NUM_CH-1:0]                   done,
    output logic [NUM_CH*NBITS_FOR_COUNTER-1:0] CountOut
);

    localparam int unsigned NB = NBITS_FOR_COUNTER;
    localparam logic [63:0] DEFAULT_MAX = 64'(BASE_CLK) / (64'(2) * 64'(TARGET_FREQUENCY));
    localparam logic [63:0] MAX_REPR    = (64'd1 << NB) - 64'd1;

    // Parameter sanity checks at elaboration time.
    if (DEFAULT_MAX == 64'd0 || DEFAULT_MAX > MAX_REPR) begin : g_bad_default_max
        $error("programmable_freq_divider: DEFAULT_MAX out of range for counter width");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("programmable_freq_divider: NUM_CH must be in 1..16");
    end

    typedef enum logic [1:0] {
        MODE_TOGGLE     = 2'b00,
        MODE_PULSE      = 2'b01,
        MODE_ONESHOT    = 2'b10,
        MODE_TOGGLE_ALT = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    logic [NB-1:0] max_q   [NUM_CH];
    mode_e         mode_q  [NUM_CH];
    logic [NB-1:0] count_q [NUM_CH];
    state_e        state_q [NUM_CH];

    logic [NB-1:0]     last_cnt [NUM_CH];
    logic [NUM_CH-1:0] terminal;
    logic              cfg_accept;
    logic              cfg_ch_ok;

    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_ch_ok  = int'(cfg_ch) < int'(NUM_CH);

    // Terminal count is M-1, with a programmed M of 0 behaving like M=1.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            last_cnt[i] = (max_q[i] == '0) ? '0 : max_q[i] - NB'(1);
            terminal[i] = (count_q[i] == last_cnt[i]);
        end
    end

    // Configuration handshake and per-channel divider state machines.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                max_q[i]   <= NB'(DEFAULT_MAX);
                mode_q[i]  <= MODE_TOGGLE;
                state_q[i] <= ST_RUN;
                count_q[i] <= '0;
                flag[i]    <= 1'b0;
                tick[i]    <= 1'b0;
                done[i]    <= 1'b0;
            end
        end else begin
            // One dead cycle after every accepted request.
            cfg_ready <= !cfg_accept;
            cfg_err   <= cfg_accept && !cfg_ch_ok;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (cfg_accept && cfg_ch_ok && int'(cfg_ch) == i) begin
                    // Reconfiguration wins over a coincident terminal count.
                    max_q[i]   <= cfg_max;
                    mode_q[i]  <= mode_e'(cfg_mode);
                    state_q[i] <= ST_RUN;
                    count_q[i] <= '0;
                    flag[i]    <= 1'b0;
                    tick[i]    <= 1'b0;
                    done[i]    <= 1'b0;
                end else begin
                    unique case (state_q[i])
                        ST_DONE: begin
                            count_q[i] <= '0;
                            flag[i]    <= 1'b1;
                            done[i]    <= 1'b1;
                            tick[i]    <= 1'b0;
                        end
                        ST_RUN: begin
                            if (!enable[i]) begin
                                tick[i] <= 1'b0;
                                // PULSE flag always tracks tick.
                                if (mode_q[i] == MODE_PULSE) begin
                                    flag[i] <= 1'b0;
                                end
                            end else if (terminal[i]) begin
                                count_q[i] <= '0;
                                tick[i]    <= 1'b1;
                                case (mode_q[i])
                                    MODE_PULSE: begin
                                        flag[i] <= 1'b1;
                                    end
                                    MODE_ONESHOT: begin
                                        flag[i]    <= 1'b1;
                                        done[i]    <= 1'b1;
                                        state_q[i] <= ST_DONE;
                                    end
                                    default: begin
                                        flag[i] <= ~flag[i];
                                    end
                                endcase
                            end else begin
                                count_q[i] <= count_q[i] + NB'(1);
                                tick[i]    <= 1'b0;
                                if (mode_q[i] == MODE_PULSE) begin
                                    flag[i] <= 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Flatten per-channel counts onto the output bus.
    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_count_out
        assign CountOut[g*NB +: NB] = count_q[g];
    end

endmodule

// File: tb/tb_programmable_freq_divider.sv
// Scoreboard bench for programmable_freq_divider: a cycle-level reference model
// based on enabled-cycle counts predicts every output; a monitor compares them.
module tb_programmable_freq_divider;

    localparam int NUM_CH = 5;
    localparam int NB     = 16;
    localparam int CH_W   = 3;
    localparam int DEF_M  = 50_000_000 / (2 * 100_000);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NUM_CH-1:0]    enable;
    logic                 cfg_valid;
    logic [CH_W-1:0]      cfg_ch;
    logic [NB-1:0]        cfg_max;
    logic [1:0]           cfg_mode;
    logic                 cfg_ready;
    logic                 cfg_err;
    logic [NUM_CH-1:0]    flag;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    done;
    logic [NUM_CH*NB-1:0] CountOut;

    programmable_freq_divider #(
        .BASE_CLK         (50_000_000),
        .TARGET_FREQUENCY (100_000),
        .NUM_CH           (NUM_CH),
        .NBITS_FOR_COUNTER(NB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_ch   (cfg_ch),
        .cfg_max  (cfg_max),
        .cfg_mode (cfg_mode),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .flag     (flag),
        .tick     (tick),
        .done     (done),
        .CountOut (CountOut)
    );

    typedef struct {
        logic [NUM_CH-1:0]    flag;
        logic [NUM_CH-1:0]    tick;
        logic [NUM_CH-1:0]    done;
        logic [NUM_CH*NB-1:0] cnt;
        logic                 ready;
        logic                 err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: k = enabled cycles since (re)configuration.
    int m_k    [NUM_CH];
    int m_max  [NUM_CH];
    int m_mode [NUM_CH];
    bit m_tick [NUM_CH];
    bit m_ready;
    bit m_err;

    function automatic int eff(int c);
        return (m_max[c] == 0) ? 1 : m_max[c];
    endfunction

    function automatic bit m_done(int c);
        return (m_mode[c] == 2) && (m_k[c] >= eff(c));
    endfunction

    task automatic model_edge();
        bit acc;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_k[c]    = 0;
                m_max[c]  = DEF_M;
                m_mode[c] = 0;
                m_tick[c] = 1'b0;
            end
            m_ready = 1'b0;
            m_err   = 1'b0;
        end else begin
            acc     = cfg_valid && m_ready;
            m_err   = acc && (int'(cfg_ch) >= NUM_CH);
            m_ready = !acc;
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc && int'(cfg_ch) == c) begin
                    m_max[c]  = int'(cfg_max);
                    m_mode[c] = int'(cfg_mode);
                    m_k[c]    = 0;
                    m_tick[c] = 1'b0;
                end else if (m_done(c)) begin
                    m_tick[c] = 1'b0;
                end else if (enable[c]) begin
                    m_k[c]    = m_k[c] + 1;
                    m_tick[c] = (m_k[c] % eff(c)) == 0;
                end else begin
                    m_tick[c] = 1'b0;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.flag = '0;
        e.tick = '0;
        e.done = '0;
        e.cnt  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            int m;
            bit d;
            m = eff(c);
            d = m_done(c);
            e.tick[c] = m_tick[c];
            e.done[c] = d;
            e.cnt[c*NB +: NB] = d ? '0 : NB'(m_k[c] % m);
            case (m_mode[c])
                1:       e.flag[c] = m_tick[c];
                2:       e.flag[c] = d;
                default: e.flag[c] = ((m_k[c] / m) % 2) == 1;
            endcase
        end
        e.ready = m_ready;
        e.err   = m_err;
        return e;
    endfunction

    // One clock edge: model predicts the post-edge outputs, then inputs may change.
    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        sb_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [NUM_CH-1:0] en);
        enable    = en;
        cfg_valid = 1'b0;
        repeat (n) clk_edge();
    endtask

    task automatic cfg(input int ch, input int mx, input int md);
        if (!m_ready) clk_edge();
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_max   = NB'(mx);
        cfg_mode  = 2'(md);
        clk_edge();
        cfg_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares each presented output set against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("flag",      128'(flag),      128'(e.flag));
                chk("tick",      128'(tick),      128'(e.tick));
                chk("done",      128'(done),      128'(e.done));
                chk("CountOut",  128'(CountOut),  128'(e.cnt));
                chk("cfg_ready", 128'(cfg_ready), 128'(e.ready));
                chk("cfg_err",   128'(cfg_err),   128'(e.err));
            end
        end
    end

    initial begin
        int guard;
        reset     = 1'b1;
        enable    = '1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_max   = '0;
        cfg_mode  = 2'b00;
        @(negedge clk);
        repeat (3) clk_edge();
        reset = 1'b0;

        // Default divide on all channels.
        run(600, '1);

        // Channel 1 PULSE with M=3, channel 2 ONESHOT with M=5 then TOGGLE restart.
        cfg(1, 3, 1);
        run(12, '1);
        cfg(2, 5, 2);
        run(15, '1);
        cfg(2, 4, 0);
        run(10, '1);

        // Channel 0 paused for 7 cycles mid-count.
        run(40, '1);
        run(7, NUM_CH'(5'b11110));
        run(260, '1);

        // Configuration landing exactly on a terminal edge of channel 3.
        cfg(3, 4, 0);
        guard = 0;
        while ((m_k[3] % 4) != 3 && guard < 10) begin
            clk_edge();
            guard++;
        end
        cfg(3, 6, 0);
        run(10, '1);

        // Back-to-back requests: every other one is accepted.
        cfg_valid = 1'b1;
        cfg_ch    = 3'd4;
        cfg_mode  = 2'b01;
        cfg_max   = 16'd2;
        repeat (4) begin
            clk_edge();
            cfg_max = cfg_max + 16'd1;
        end
        cfg_valid = 1'b0;
        run(10, '1);

        // Requests to channels that do not exist.
        cfg(5, 9, 1);
        run(3, '1);
        cfg(7, 2, 2);
        run(3, '1);

        // Randomized traffic, including M=0/1 and occasional resets.
        repeat (2500) begin
            enable    = NUM_CH'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom);
            cfg_max   = NB'($urandom_range(0, 7));
            cfg_mode  = 2'($urandom);
            reset     = ($urandom_range(0, 199) == 0);
            clk_edge();
        end
        reset     = 1'b0;
        cfg_valid = 1'b0;

        // Reset in the middle of activity, then the default sequence again.
        run(37, '1);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_max   = 16'd3;
        reset     = 1'b1;
        clk_edge();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        run(520, '1);

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
